// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial
// Digit-serial packed-BCD subtractor. A captured request subtracts b from a
// one digit per clock (LSD first). If the result went negative, a second
// digit-serial pass converts the tens-complement result back to a magnitude.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request, accepted only while idle
//   a, b   : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy   : high whenever the block is not idle
//   done   : one-cycle pulse; diff/neg/err valid while high
//   diff   : |a-b|, packed BCD
//   neg    : a < b
//   err    : an input digit was above 9 (diff and neg forced to 0)
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] a_r, b_r, diff_r, diff_upd;
  logic                borrow, borrow_nxt;
  logic                neg_r, err_r;
  logic [2:0]          idx;
  logic [3:0]          x_d, y_d, res_d;
  logic [4:0]          t;
  logic                last, bad_in;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in = has_bad_digit(a) | has_bad_digit(b);
  assign last   = (idx == LAST);

  // One shared digit subtractor. SUB computes a_i - b_i - borrow; COMP
  // computes 0 - diff_i - borrow, which ripples a tens complement.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    x_d = '0;
    y_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        x_d = (state == COMP) ? 4'd0 : a_r[i*4 +: 4];
        y_d = (state == COMP) ? diff_r[i*4 +: 4] : b_r[i*4 +: 4];
      end
    end
    // 5-bit two's complement holds -10..9, so bit 4 is the borrow out.
    t          = {1'b0, x_d} - {1'b0, y_d} - {4'b0, borrow};
    borrow_nxt = t[4];
    res_d      = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    diff_upd   = diff_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) diff_upd[i*4 +: 4] = res_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = SUB;
      // A bad-digit request spends one SUB cycle and skips all digit work.
      SUB:  if (err_r)     state_nxt = DONE;
            else if (last) state_nxt = borrow_nxt ? COMP : DONE;
      COMP: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      neg_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_r    <= a;
          b_r    <= b;
          diff_r <= '0;
          borrow <= 1'b0;
          idx    <= '0;
          neg_r  <= 1'b0;
          err_r  <= bad_in;
        end
        SUB: if (!err_r) begin
          diff_r <= diff_upd;
          if (last) begin
            // Borrow and index restart from zero for a possible COMP pass.
            borrow <= 1'b0;
            idx    <= '0;
          end else begin
            borrow <= borrow_nxt;
            idx    <= idx + 3'd1;
          end
        end
        COMP: begin
          diff_r <= diff_upd;
          if (last) begin
            borrow <= 1'b0;
            idx    <= '0;
            neg_r  <= 1'b1;
          end else begin
            borrow <= borrow_nxt;
            idx    <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign diff = diff_r;
  assign neg  = neg_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial
// Self-checking bench for bcd_sub_serial (DIGITS=4): directed cases followed
// by random requests checked against an integer-arithmetic reference model.
module tb_bcd_sub_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, neg, err;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  bcd_sub_serial #(.DIGITS(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .neg  (neg),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] v;
    int           y;
    v = '0;
    y = x;
    for (int i = 0; i < D; i++) begin
      v[i*4 +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return v;
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // Issue one request, measure latency from the capture edge, then check
  // results, the single-cycle done pulse and that outputs hold afterwards.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    logic [W-1:0] exp_diff;
    logic         exp_neg, exp_err;
    int           exp_lat, ia, ib, n;
    exp_err = bad_bcd(av) | bad_bcd(bv);
    ia = bcd2int(av);
    ib = bcd2int(bv);
    if (exp_err) begin
      exp_diff = '0; exp_neg = 1'b0; exp_lat = 1;
    end else if (ia >= ib) begin
      exp_diff = int2bcd(ia - ib); exp_neg = 1'b0; exp_lat = D;
    end else begin
      exp_diff = int2bcd(ib - ia); exp_neg = 1'b1; exp_lat = 2 * D;
    end

    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);            // capture edge k
    #1;
    start = 1'b0;
    a = W'($urandom);          // captured operands must not follow the inputs
    b = W'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      check({tag, " busy"}, 32'(busy), 32'd1);
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " diff"}, 32'(diff), 32'(exp_diff));
    check({tag, " neg"}, 32'(neg), 32'(exp_neg));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
    check({tag, " diff_hold"}, 32'(diff), 32'(exp_diff));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           n;
    logic         saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset neg", 32'(neg), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(16'h0042, 16'h0017, "d42m17");
    run_op(16'h0100, 16'h0001, "ripple");
    run_op(16'h0000, 16'h9999, "zero_m_max");
    run_op(16'h0017, 16'h0042, "d17m42");
    run_op(16'h00A0, 16'h0001, "bad_a");
    run_op(16'h0003, 16'h00F0, "bad_b");
    run_op(16'h1234, 16'h1234, "equal");
    run_op(16'h9999, 16'h0000, "max_m_zero");

    // Start while busy is ignored
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; start = 1'b1;
    @(posedge clk);            // edge k
    #1 start = 1'b0;
    @(posedge clk);            // edge k+1
    @(negedge clk);
    a = 16'h0000; b = 16'h9999; start = 1'b1;
    @(posedge clk);            // edge k+2
    #1 start = 1'b0;
    n = 2;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("busy_start latency", 32'(n), 32'd4);
    check("busy_start diff", 32'(diff), 32'h0025);
    check("busy_start neg", 32'(neg), 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("busy_start no_second_done", 32'(saw_done), 32'd0);

    // Reset in the middle of an a<b operation
    @(negedge clk);
    a = 16'h0017; b = 16'h0042; start = 1'b1;
    @(posedge clk);            // edge k
    #1 start = 1'b0;
    @(posedge clk);            // edge k+1
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);            // edge k+2
    #1;
    check("midrst outputs", {27'd0, busy, done, neg, err, |diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst quiet", 32'(saw_done), 32'd0);
    run_op(16'h0042, 16'h0017, "after_rst");

    // Random requests, roughly one in eight with an illegal digit
    for (int k = 0; k < 40; k++) begin
      ra = '0;
      rb = '0;
      for (int i = 0; i < D; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0)
          ra[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
        else
          rb[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
      end
      run_op(ra, rb, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
